// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: single-outstanding imem request, one-entry decode buffer
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jb,
    input  logic [31:0] jb_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] current_pc,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic        buf_valid;
    logic [31:0] jb_target;

    assign jb_target = jb_pc & ~32'd3;

    // A request may only go out when the buffer slot will be free by the next edge.
    assign imem_req  = rst && (state == ISSUE) && !jb && (!buf_valid || !stall);
    assign imem_addr = pc;

    assign inst_valid = buf_valid;
    assign inst       = buf_valid ? buf_inst : NOP_INST;
    assign current_pc = buf_valid ? buf_pc : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= RESET_PC & ~32'd3;
            state     <= ISSUE;
            buf_valid <= 1'b0;
            buf_inst  <= NOP_INST;
            buf_pc    <= 32'd0;
        end else begin
            if (jb || (buf_valid && !stall)) begin
                buf_valid <= 1'b0;
            end
            case (state)
                ISSUE: begin
                    if (jb) begin
                        pc <= jb_target;
                    end else if (imem_req) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= ISSUE;
                        if (jb) begin
                            pc <= jb_target;
                        end else begin
                            buf_inst  <= imem_rdata;
                            buf_pc    <= pc;
                            buf_valid <= 1'b1;
                            pc        <= pc + 32'd4;
                        end
                    end else if (jb) begin
                        pc    <= jb_target;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The in-flight response belongs to the squashed path; drop it.
                    if (jb) begin
                        pc <= jb_target;
                    end
                    if (imem_rvalid) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, is the bubble instruction (addi x0,x0,0).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 stall  in  1  hazard hold: decode register does not capture this edge.
REQ-006 jb  in  1  jump/branch taken; redirect fetch to jb_pc.
REQ-007 jb_pc  in  32  redirect target.
REQ-008 imem_req  out  1  instruction request; accepted by memory in the same cycle.
REQ-009 imem_addr  out  32  request address, word aligned.
REQ-010 imem_rvalid  in  1  response valid, at least 1 cycle after request, in order.
REQ-011 imem_rdata  in  32  response instruction word.
REQ-012 inst  out  32  instruction to decode register.
REQ-013 current_pc  out  32  PC of inst.
REQ-014 inst_valid  out  1  inst/current_pc hold a real fetched instruction.

Function
REQ-015 The unit SHALL keep at most one imem request outstanding and a one-entry output buffer (buf_inst, buf_pc, buf_valid).
REQ-016 Outputs SHALL be driven from the buffer: buf_valid=1 -> inst=buf_inst, current_pc=buf_pc, inst_valid=1; else inst=NOP_INST, current_pc=0, inst_valid=0.
REQ-017 The buffer entry SHALL be consumed (buf_valid<=0) on any edge with buf_valid=1 and stall=0; with stall=1 and jb=0 it SHALL hold unchanged.
REQ-018 States: ISSUE (ready to request), WAIT (request outstanding), DRAIN (outstanding response to discard).
REQ-019 ISSUE: imem_req=1, imem_addr=pc only when jb=0 and (buf_valid=0 or stall=0); the state then moves to WAIT; otherwise imem_req=0 and the state stays ISSUE.
REQ-020 WAIT, imem_rvalid=1, jb=0: buffer <= {imem_rdata, pc}, buf_valid<=1, pc<=pc+4, next ISSUE.
REQ-021 WAIT, imem_rvalid=0, jb=1: pc<=jb_pc, next DRAIN.
REQ-022 WAIT, imem_rvalid=1, jb=1: discard response, pc<=jb_pc, next ISSUE.
REQ-023 DRAIN: imem_req=0; on imem_rvalid discard data and go to ISSUE; jb in DRAIN updates pc<=jb_pc and keeps DRAIN unless rvalid also arrives.
REQ-024 jb=1 SHALL flush the buffer (buf_valid<=0) on that edge and SHALL take priority over stall.
REQ-025 jb in ISSUE SHALL suppress imem_req that cycle and load pc<=jb_pc.
REQ-026 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 jb_pc[1:0] SHALL be ignored; pc[1:0] and imem_addr[1:0] are always 2'b00.
REQ-028 imem_rvalid in ISSUE SHALL be ignored (no state or buffer change).
REQ-029 When imem_req=0, imem_addr SHALL equal pc.
REQ-030 Fetch-to-output latency SHALL be memory latency plus 1 cycle (response registered into buffer).

Reset
REQ-031 While rst=0, imem_req SHALL be 0 combinationally.
REQ-032 On an edge with rst=0: pc<=RESET_PC, state<=ISSUE, buf_valid<=0, buf_inst<=NOP_INST, buf_pc<=0.
REQ-033 Reset SHALL override stall, jb and imem_rvalid; a response arriving after reset in ISSUE is dropped per REQ-028.
REQ-034 The first request after reset SHALL issue in the first cycle with rst=1, addr=RESET_PC.

Verification
REQ-035 Reset release, 1-cycle memory returning 32'h00500093 at 0: imem_req at addr 0, then inst=32'h00500093, current_pc=0, inst_valid=1 two cycles after request; next request addr 4.
REQ-036 stall=1 for 3 cycles with buffer full: inst/current_pc held, no new imem_req; stall=0 -> request addr pc resumes next cycle.
REQ-037 jb=1, jb_pc=32'h0000_0103 while WAIT (3-cycle memory): late response discarded, inst_valid=0, next request addr 32'h0000_0100.
REQ-038 jb and imem_rvalid same cycle: data dropped, buffer empty, next request addr jb_pc.
REQ-039 pc=32'hFFFF_FFFC fetch: current_pc=32'hFFFF_FFFC, next request addr 0.
REQ-040 rst=0 asserted while WAIT: imem_req=0 immediately; after release, first request addr RESET_PC; stale rvalid ignored.
